tilelink_ad_arbiter: RTL and testbench

Two-master to one-slave TileLink-UL A/D channel arbiter that shares a single memory slave (e.g. the formal dummy TileLink slave) between two requesters such as a core's fetch and data ports. It grants the A channel round-robin, keeps one transaction in flight at a time, counts A and D burst beats, and routes the D response back to the owning master. It sits between the masters' `io_master_*` ports and the slave's `channel_a_*` / `channel_d_*` ports in the formal wrapper.

---
 rtl/tilelink_ad_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_tilelink_ad_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilelink_ad_arbiter.sv
// tilelink_ad_arbiter: two-master to one-slave TileLink-UL A/D arbiter.
// Round-robin A grant, one transaction in flight, A/D beat counting, and
// D response routing back to the owning master.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   mN_a_*  (N = 0, 1)      A channel from master N (ready out, valid/bits in)
//   mN_d_*                  D channel to master N (valid/bits out, ready in)
//   s_a_*                   A channel to the slave (valid/bits out, ready in)
//   s_d_*                   D channel from the slave (valid/bits in, ready out)
//   grant                   one-hot current owner, 0 when idle
//   err                     sticky watchdog error flag
// Optional feature: define TL_ARB_WATCHDOG_EN to build the D_WAIT watchdog.
module tilelink_ad_arbiter #(
    parameter int TIMEOUT  = 255,
    parameter int MAX_SIZE = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        m0_a_ready,
    input  logic        m0_a_valid,
    input  logic [2:0]  m0_a_bits_opcode,
    input  logic [2:0]  m0_a_bits_param,
    input  logic [3:0]  m0_a_bits_size,
    input  logic        m0_a_bits_source,
    input  logic [31:0] m0_a_bits_address,
    input  logic [3:0]  m0_a_bits_mask,
    input  logic [31:0] m0_a_bits_data,
    input  logic        m0_d_ready,
    output logic        m0_d_valid,
    output logic [2:0]  m0_d_bits_opcode,
    output logic [1:0]  m0_d_bits_param,
    output logic [3:0]  m0_d_bits_size,
    output logic        m0_d_bits_source,
    output logic        m0_d_bits_sink,
    output logic [1:0]  m0_d_bits_addr_lo,
    output logic [31:0] m0_d_bits_data,
    output logic        m0_d_bits_error,
    output logic        m1_a_ready,
    input  logic        m1_a_valid,
    input  logic [2:0]  m1_a_bits_opcode,
    input  logic [2:0]  m1_a_bits_param,
    input  logic [3:0]  m1_a_bits_size,
    input  logic        m1_a_bits_source,
    input  logic [31:0] m1_a_bits_address,
    input  logic [3:0]  m1_a_bits_mask,
    input  logic [31:0] m1_a_bits_data,
    input  logic        m1_d_ready,
    output logic        m1_d_valid,
    output logic [2:0]  m1_d_bits_opcode,
    output logic [1:0]  m1_d_bits_param,
    output logic [3:0]  m1_d_bits_size,
    output logic        m1_d_bits_source,
    output logic        m1_d_bits_sink,
    output logic [1:0]  m1_d_bits_addr_lo,
    output logic [31:0] m1_d_bits_data,
    output logic        m1_d_bits_error,
    input  logic        s_a_ready,
    output logic        s_a_valid,
    output logic [2:0]  s_a_bits_opcode,
    output logic [2:0]  s_a_bits_param,
    output logic [3:0]  s_a_bits_size,
    output logic        s_a_bits_source,
    output logic [31:0] s_a_bits_address,
    output logic [3:0]  s_a_bits_mask,
    output logic [31:0] s_a_bits_data,
    output logic        s_d_ready,
    input  logic        s_d_valid,
    input  logic [2:0]  s_d_bits_opcode,
    input  logic [1:0]  s_d_bits_param,
    input  logic [3:0]  s_d_bits_size,
    input  logic        s_d_bits_source,
    input  logic        s_d_bits_sink,
    input  logic [1:0]  s_d_bits_addr_lo,
    input  logic [31:0] s_d_bits_data,
    input  logic        s_d_bits_error,
    output logic [1:0]  grant,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, A_BURST, D_WAIT} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic        err_q, err_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  a_vld;
    logic        sel, a_open, d_open, a_hs, d_hs;
    logic [3:0]  sz_c;
    logic [4:0]  nb;

    assign a_vld = {m1_a_valid, m0_a_valid};

    // In IDLE the preferred master wins unless only the other one is asking;
    // once a transaction is running the owner holds the A path.
    assign sel = (state_q == IDLE) ? ((a_vld[ptr_q] || !a_vld[~ptr_q]) ? ptr_q : ~ptr_q) : owner_q;

    // Valid/ready outputs are gated with reset so they are 0 while in reset.
    assign a_open     = reset && (state_q != D_WAIT);
    assign d_open     = reset && (state_q == D_WAIT);
    assign s_a_valid  = a_open && a_vld[sel];
    assign m0_a_ready = a_open && !sel && s_a_ready;
    assign m1_a_ready = a_open && sel && s_a_ready;
    assign a_hs       = s_a_valid && s_a_ready;

    assign s_a_bits_opcode  = sel ? m1_a_bits_opcode  : m0_a_bits_opcode;
    assign s_a_bits_param   = sel ? m1_a_bits_param   : m0_a_bits_param;
    assign s_a_bits_size    = sel ? m1_a_bits_size    : m0_a_bits_size;
    assign s_a_bits_source  = sel ? m1_a_bits_source  : m0_a_bits_source;
    assign s_a_bits_address = sel ? m1_a_bits_address : m0_a_bits_address;
    assign s_a_bits_mask    = sel ? m1_a_bits_mask    : m0_a_bits_mask;
    assign s_a_bits_data    = sel ? m1_a_bits_data    : m0_a_bits_data;

    assign m0_d_valid = d_open && !owner_q && s_d_valid;
    assign m1_d_valid = d_open && owner_q && s_d_valid;
    assign s_d_ready  = d_open && (owner_q ? m1_d_ready : m0_d_ready);
    assign d_hs       = s_d_valid && s_d_ready;

    assign m0_d_bits_opcode  = s_d_bits_opcode;
    assign m0_d_bits_param   = s_d_bits_param;
    assign m0_d_bits_size    = s_d_bits_size;
    assign m0_d_bits_source  = s_d_bits_source;
    assign m0_d_bits_sink    = s_d_bits_sink;
    assign m0_d_bits_addr_lo = s_d_bits_addr_lo;
    assign m0_d_bits_data    = s_d_bits_data;
    assign m0_d_bits_error   = s_d_bits_error;
    assign m1_d_bits_opcode  = s_d_bits_opcode;
    assign m1_d_bits_param   = s_d_bits_param;
    assign m1_d_bits_size    = s_d_bits_size;
    assign m1_d_bits_source  = s_d_bits_source;
    assign m1_d_bits_sink    = s_d_bits_sink;
    assign m1_d_bits_addr_lo = s_d_bits_addr_lo;
    assign m1_d_bits_data    = s_d_bits_data;
    assign m1_d_bits_error   = s_d_bits_error;

    // Beats of 32 bit: max(1, bytes / 4), with the size clamped first.
    assign sz_c = (s_a_bits_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : s_a_bits_size;
    assign nb   = (sz_c <= 4'd2) ? 5'd1 : 5'(32'd1 << (sz_c - 4'd2));

    assign grant = grant_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        err_d   = err_q;
        wd_d    = 8'd0;
        case (state_q)
            IDLE: begin
                if (a_hs) begin
                    owner_d = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    if ((s_a_bits_opcode == 3'd0 || s_a_bits_opcode == 3'd1) && nb > 5'd1) begin
                        state_d = A_BURST;
                        cnt_d   = nb - 5'd1;
                    end else begin
                        state_d = D_WAIT;
                        cnt_d   = (s_a_bits_opcode == 3'd4) ? nb : 5'd1;
                    end
                end
            end
            A_BURST: begin
                if (a_hs) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = D_WAIT;
                        cnt_d   = 5'd1;
                    end
                end
            end
            D_WAIT: begin
                if (d_hs) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        ptr_d   = ~owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TL_ARB_WATCHDOG_EN
        // Counts stalled D_WAIT cycles; firing abandons the transaction.
        if (state_q == D_WAIT && !d_hs) begin
            wd_d = wd_q + 8'd1;
            if (wd_q == 8'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
                grant_d = 2'b00;
                ptr_d   = ~owner_q;
                cnt_d   = 5'd0;
                wd_d    = 8'd0;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 5'd0;
            grant_q <= 2'b00;
            err_q   <= 1'b0;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

`ifdef TL_ARB_WATCHDOG_EN
    assign err = err_q;
`else
    // Without the watchdog the counter and flag stay at their reset values.
    logic unused_wd;
    assign unused_wd = ^{wd_q, err_q, 8'(TIMEOUT)};
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tilelink_ad_arbiter.sv
// tb_tilelink_ad_arbiter: directed self-checking bench for tilelink_ad_arbiter.
module tb_tilelink_ad_arbiter;
    logic        clock, reset;
    logic        m0_a_ready, m0_a_valid, m0_a_bits_source, m0_d_ready, m0_d_valid;
    logic [2:0]  m0_a_bits_opcode, m0_a_bits_param, m0_d_bits_opcode;
    logic [3:0]  m0_a_bits_size, m0_a_bits_mask, m0_d_bits_size;
    logic [31:0] m0_a_bits_address, m0_a_bits_data, m0_d_bits_data;
    logic [1:0]  m0_d_bits_param, m0_d_bits_addr_lo;
    logic        m0_d_bits_source, m0_d_bits_sink, m0_d_bits_error;
    logic        m1_a_ready, m1_a_valid, m1_a_bits_source, m1_d_ready, m1_d_valid;
    logic [2:0]  m1_a_bits_opcode, m1_a_bits_param, m1_d_bits_opcode;
    logic [3:0]  m1_a_bits_size, m1_a_bits_mask, m1_d_bits_size;
    logic [31:0] m1_a_bits_address, m1_a_bits_data, m1_d_bits_data;
    logic [1:0]  m1_d_bits_param, m1_d_bits_addr_lo;
    logic        m1_d_bits_source, m1_d_bits_sink, m1_d_bits_error;
    logic        s_a_ready, s_a_valid, s_a_bits_source, s_d_ready, s_d_valid;
    logic [2:0]  s_a_bits_opcode, s_a_bits_param, s_d_bits_opcode;
    logic [3:0]  s_a_bits_size, s_a_bits_mask, s_d_bits_size;
    logic [31:0] s_a_bits_address, s_a_bits_data, s_d_bits_data;
    logic [1:0]  s_d_bits_param, s_d_bits_addr_lo;
    logic        s_d_bits_source, s_d_bits_sink, s_d_bits_error;
    logic [1:0]  grant;
    logic        err;
    int          total = 0;
    int          bad = 0;

    tilelink_ad_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_a_ready(m0_a_ready), .m0_a_valid(m0_a_valid), .m0_a_bits_opcode(m0_a_bits_opcode),
        .m0_a_bits_param(m0_a_bits_param), .m0_a_bits_size(m0_a_bits_size), .m0_a_bits_source(m0_a_bits_source),
        .m0_a_bits_address(m0_a_bits_address), .m0_a_bits_mask(m0_a_bits_mask), .m0_a_bits_data(m0_a_bits_data),
        .m0_d_ready(m0_d_ready), .m0_d_valid(m0_d_valid), .m0_d_bits_opcode(m0_d_bits_opcode),
        .m0_d_bits_param(m0_d_bits_param), .m0_d_bits_size(m0_d_bits_size), .m0_d_bits_source(m0_d_bits_source),
        .m0_d_bits_sink(m0_d_bits_sink), .m0_d_bits_addr_lo(m0_d_bits_addr_lo), .m0_d_bits_data(m0_d_bits_data),
        .m0_d_bits_error(m0_d_bits_error),
        .m1_a_ready(m1_a_ready), .m1_a_valid(m1_a_valid), .m1_a_bits_opcode(m1_a_bits_opcode),
        .m1_a_bits_param(m1_a_bits_param), .m1_a_bits_size(m1_a_bits_size), .m1_a_bits_source(m1_a_bits_source),
        .m1_a_bits_address(m1_a_bits_address), .m1_a_bits_mask(m1_a_bits_mask), .m1_a_bits_data(m1_a_bits_data),
        .m1_d_ready(m1_d_ready), .m1_d_valid(m1_d_valid), .m1_d_bits_opcode(m1_d_bits_opcode),
        .m1_d_bits_param(m1_d_bits_param), .m1_d_bits_size(m1_d_bits_size), .m1_d_bits_source(m1_d_bits_source),
        .m1_d_bits_sink(m1_d_bits_sink), .m1_d_bits_addr_lo(m1_d_bits_addr_lo), .m1_d_bits_data(m1_d_bits_data),
        .m1_d_bits_error(m1_d_bits_error),
        .s_a_ready(s_a_ready), .s_a_valid(s_a_valid), .s_a_bits_opcode(s_a_bits_opcode),
        .s_a_bits_param(s_a_bits_param), .s_a_bits_size(s_a_bits_size), .s_a_bits_source(s_a_bits_source),
        .s_a_bits_address(s_a_bits_address), .s_a_bits_mask(s_a_bits_mask), .s_a_bits_data(s_a_bits_data),
        .s_d_ready(s_d_ready), .s_d_valid(s_d_valid), .s_d_bits_opcode(s_d_bits_opcode),
        .s_d_bits_param(s_d_bits_param), .s_d_bits_size(s_d_bits_size), .s_d_bits_source(s_d_bits_source),
        .s_d_bits_sink(s_d_bits_sink), .s_d_bits_addr_lo(s_d_bits_addr_lo), .s_d_bits_data(s_d_bits_data),
        .s_d_bits_error(s_d_bits_error),
        .grant(grant), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic v0, v1, sar, sdv;
        logic e_sav, e_r0, e_r1, e_sel;
        logic [1:0] e_grant;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_in();
        m0_a_valid = 0; m1_a_valid = 0; s_a_ready = 1; m0_d_ready = 1; m1_d_ready = 1; s_d_valid = 0;
        m0_a_bits_param = 0; m0_a_bits_source = 0; m0_a_bits_mask = 4'hf; m0_a_bits_data = 32'h0a0a0a0a;
        m1_a_bits_param = 0; m1_a_bits_source = 1; m1_a_bits_mask = 4'hf; m1_a_bits_data = 32'h1b1b1b1b;
        s_d_bits_opcode = 3'd1; s_d_bits_param = 0; s_d_bits_size = 4'd2; s_d_bits_source = 0;
        s_d_bits_sink = 0; s_d_bits_addr_lo = 0; s_d_bits_data = 0; s_d_bits_error = 0;
    endtask

    task automatic set_a(input int m, input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [31:0] ad);
        if (m == 0) begin
            m0_a_valid = v; m0_a_bits_opcode = op; m0_a_bits_size = sz; m0_a_bits_address = ad;
        end else begin
            m1_a_valid = v; m1_a_bits_opcode = op; m1_a_bits_size = sz; m1_a_bits_address = ad;
        end
    endtask

    task automatic do_reset();
        reset = 0;
        idle_in();
        tick();
        reset = 1;
    endtask

    // Delivers n D beats to master m, checking routing on every beat.
    task automatic do_d(input int m, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            s_d_valid = 1;
            s_d_bits_data = base + i;
            #1;
            chk("d_valid_owner", (m == 0) ? m0_d_valid : m1_d_valid, 1);
            chk("d_valid_other", (m == 0) ? m1_d_valid : m0_d_valid, 0);
            chk("d_data_owner", (m == 0) ? m0_d_bits_data : m1_d_bits_data, base + i);
            chk("grant_in_d", grant, (m == 0) ? 2'b01 : 2'b10);
            tick();
        end
        s_d_valid = 0;
    endtask

    initial begin
        vec_t vt[7];
        vt[0] = '{0, 0, 1, 0, 0, 1, 0, 0, 2'b00};
        vt[1] = '{1, 0, 1, 0, 1, 1, 0, 0, 2'b01};
        vt[2] = '{0, 1, 1, 0, 1, 0, 1, 1, 2'b10};
        vt[3] = '{1, 1, 1, 0, 1, 1, 0, 0, 2'b01};
        vt[4] = '{1, 1, 0, 0, 1, 0, 0, 0, 2'b00};
        vt[5] = '{0, 1, 0, 1, 1, 0, 0, 1, 2'b00};
        vt[6] = '{0, 0, 0, 1, 0, 0, 0, 0, 2'b00};

        // Reset state, with requests present to show the gating.
        reset = 0;
        idle_in();
        set_a(0, 1, 3'd4, 4'd2, 32'h10);
        s_d_valid = 1;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_err", err, 0);
        chk("rst_m0_a_ready", m0_a_ready, 0);
        chk("rst_s_a_valid", s_a_valid, 0);
        chk("rst_s_d_ready", s_d_ready, 0);
        chk("rst_m0_d_valid", m0_d_valid, 0);

        // IDLE arbitration table, each row from a fresh reset (ptr = 0).
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_a(0, vt[i].v0, 3'd4, 4'd2, 32'h1000);
            set_a(1, vt[i].v1, 3'd4, 4'd2, 32'h2000);
            s_a_ready = vt[i].sar;
            s_d_valid = vt[i].sdv;
            #1;
            chk("tbl_s_a_valid", s_a_valid, vt[i].e_sav);
            chk("tbl_m0_a_ready", m0_a_ready, vt[i].e_r0);
            chk("tbl_m1_a_ready", m1_a_ready, vt[i].e_r1);
            chk("tbl_s_a_addr", s_a_bits_address, vt[i].e_sel ? 32'h2000 : 32'h1000);
            chk("tbl_s_d_ready", s_d_ready, 0);
            chk("tbl_d_valids", {m1_d_valid, m0_d_valid}, 0);
            tick();
            chk("tbl_grant", grant, vt[i].e_grant);
        end

        // m0 Get size 2, one D beat, then ptr points at m1.
        do_reset();
        set_a(0, 1, 3'd4, 4'd2, 32'h100);
        tick();
        m0_a_valid = 0;
        chk("s1_grant", grant, 2'b01);
        do_d(0, 1, 32'hcafe0000);
        chk("s1_grant_idle", grant, 0);
        set_a(0, 1, 3'd4, 4'd2, 32'h100);
        set_a(1, 1, 3'd4, 4'd2, 32'h200);
        #1;
        chk("s1_ptr_m1_addr", s_a_bits_address, 32'h200);
        chk("s1_ptr_m1_ready", m1_a_ready, 1);
        chk("s1_ptr_m0_ready", m0_a_ready, 0);
        tick();
        m1_a_valid = 0;
        chk("s1_grant_m1", grant, 2'b10);
        do_d(1, 1, 32'h11110000);
        tick();
        m0_a_valid = 0;
        chk("s1_grant_m0_again", grant, 2'b01);
        do_d(0, 1, 32'h22220000);

        // Both Get together from reset: m0 first, m1 blocked until the bubble.
        do_reset();
        set_a(0, 1, 3'd4, 4'd2, 32'h100);
        set_a(1, 1, 3'd4, 4'd2, 32'h200);
        #1;
        chk("s2_m0_ready", m0_a_ready, 1);
        chk("s2_m1_ready", m1_a_ready, 0);
        tick();
        m0_a_valid = 0;
        chk("s2_grant_m0", grant, 2'b01);
        chk("s2_m1_blocked", m1_a_ready, 0);
        tick();
        chk("s2_m1_blocked_stall", m1_a_ready, 0);
        s_d_valid = 1;
        #1;
        chk("s2_m1_blocked_dbeat", m1_a_ready, 0);
        do_d(0, 1, 32'h33330000);
        #1;
        chk("s2_bubble_grant", grant, 0);
        chk("s2_m1_ready_bubble", m1_a_ready, 1);
        chk("s2_m1_addr", s_a_bits_address, 32'h200);
        tick();
        m1_a_valid = 0;
        chk("s2_grant_m1", grant, 2'b10);
        do_d(1, 1, 32'h44440000);
        chk("s2_grant_done", grant, 0);

        // m1 Get size 4: four beats to m1 only.
        set_a(1, 1, 3'd4, 4'd4, 32'h240);
        tick();
        m1_a_valid = 0;
        chk("s3_grant", grant, 2'b10);
        do_d(1, 4, 32'h55550000);
        chk("s3_idle", grant, 0);

        // Oversized Get clamps to 64 B = 16 beats.
        set_a(0, 1, 3'd4, 4'd9, 32'h400);
        tick();
        m0_a_valid = 0;
        do_d(0, 15, 32'h66660000);
        chk("clamp_not_done", grant, 2'b01);
        do_d(0, 1, 32'h6666000f);
        chk("clamp_done", grant, 0);

        // m0 PutFull size 3: two A beats, m1 blocked, one AccessAck.
        set_a(0, 1, 3'd0, 4'd3, 32'h300);
        #1;
        chk("s4_beat1_ready", m0_a_ready, 1);
        tick();
        chk("s4_grant", grant, 2'b01);
        set_a(0, 1, 3'd0, 4'd3, 32'h304);
        set_a(1, 1, 3'd4, 4'd2, 32'h500);
        #1;
        chk("s4_beat2_addr", s_a_bits_address, 32'h304);
        chk("s4_beat2_ready", m0_a_ready, 1);
        chk("s4_m1_blocked", m1_a_ready, 0);
        tick();
        m0_a_valid = 0;
        #1;
        chk("s4_dwait_s_a_valid", s_a_valid, 0);
        chk("s4_dwait_m1_ready", m1_a_ready, 0);
        s_d_bits_opcode = 3'd0;
        do_d(0, 1, 32'h0);
        chk("s4_idle", grant, 0);
        tick();
        m1_a_valid = 0;
        chk("s4_m1_next", grant, 2'b10);
        do_d(1, 1, 32'h77770000);

        // Slave D stalled.
        set_a(0, 1, 3'd4, 4'd2, 32'h600);
        tick();
        m0_a_valid = 0;
`ifdef TL_ARB_WATCHDOG_EN
        repeat (254) tick();
        chk("wd_err_before", err, 0);
        chk("wd_grant_before", grant, 2'b01);
        tick();
        chk("wd_err_fired", err, 1);
        chk("wd_grant_idle", grant, 0);
        repeat (45) tick();
        chk("wd_err_sticky", err, 1);
        do_reset();
        chk("wd_err_cleared", err, 0);
`else
        repeat (300) tick();
        set_a(1, 1, 3'd4, 4'd2, 32'h700);
        #1;
        chk("stall_err", err, 0);
        chk("stall_grant", grant, 2'b01);
        chk("stall_m1_blocked", m1_a_ready, 0);
        m1_a_valid = 0;
        do_d(0, 1, 32'h88880000);
        chk("stall_done", grant, 0);
`endif

        // Reset during D beat 2 of 4.
        set_a(1, 1, 3'd4, 4'd4, 32'h800);
        #1;
        chk("mr_m1_ready", m1_a_ready, 1);
        tick();
        m1_a_valid = 0;
        chk("mr_grant", grant, 2'b10);
        do_d(1, 1, 32'h99990000);
        s_d_valid = 1;
        set_a(0, 1, 3'd4, 4'd2, 32'h900);
        set_a(1, 1, 3'd4, 4'd2, 32'ha00);
        #1;
        chk("mr_beat2_valid", m1_d_valid, 1);
        reset = 0;
        #1;
        chk("mr_d_valid", {m1_d_valid, m0_d_valid}, 0);
        chk("mr_s_d_ready", s_d_ready, 0);
        chk("mr_a_ready", {m1_a_ready, m0_a_ready}, 0);
        chk("mr_s_a_valid", s_a_valid, 0);
        chk("mr_grant_rst", grant, 0);
        tick();
        reset = 1;
        s_d_valid = 0;
        #1;
        chk("mr_grant_after", grant, 0);
        chk("mr_ptr0_addr", s_a_bits_address, 32'h900);
        chk("mr_ptr0_ready", m0_a_ready, 1);
        tick();
        m0_a_valid = 0;
        m1_a_valid = 0;
        chk("mr_grant_m0", grant, 2'b01);
        do_d(0, 1, 32'haaaa0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
